// File: rtl/mdu_sequencer_pkg.sv
// ---- mdu_sequencer_pkg: shared MDU types and constants | rev 1.0 ----
`default_nettype none

package mdu_sequencer_pkg;

  typedef enum logic [0:0] {MDU_MULTU, MDU_DIVU} mdu_op_t;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_COMMIT} mdu_state_t;

  localparam int MDU_CYCLES = 32;

endpackage

`default_nettype wire

// File: rtl/mdu_iter_step.sv
// ---- mdu_iter_step: one radix-2 shift-add multiply / restoring divide step | rev 1.0 ----
`default_nettype none

module mdu_iter_step
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = MDU_CYCLES
) (
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    sum    = {1'b0, acc_hi_i} + ({(WIDTH+1){acc_lo_i[0]}} & {1'b0, opb_i});
    rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_i};
    // Remainder stays below the divisor, so the top bit of the W+1-bit trial is the borrow.
    borrow = diff[WIDTH];

    acc_hi_o = '0;
    acc_lo_o = '0;
    if (op_i == MDU_MULTU) begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end else begin
      acc_hi_o = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], ~borrow};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// ---- mdu_sequencer: iterative MULTU/DIVU sequencer with HI/LO registers and stall control | rev 1.0 ----
`default_nettype none

module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = MDU_CYCLES
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] rs_value_i,
  input  logic [WIDTH-1:0] rt_value_i,
  input  logic             read_req_i,
  input  logic             read_sel_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  mdu_op_t          op_q;
  logic [WIDTH-1:0] opb_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             accept, div_zero;

  assign accept   = (state_q == MDU_IDLE) && start_i;
  assign div_zero = (op_i == MDU_DIVU) && (rt_value_i == '0);

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .op_i     (op_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opb_i    (opb_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          count_d = '0;
          state_d = div_zero ? MDU_COMMIT : MDU_RUN;
        end
      end
      MDU_RUN: begin
        busy_o  = 1'b1;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          count_d = '0;
          state_d = MDU_COMMIT;
        end
      end
      MDU_COMMIT: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign stall_o     = busy_o & (read_req_i | start_i);
  assign read_data_o = read_sel_i ? hi_q : lo_q;

  // Operands live only in the accumulator until COMMIT, so an aborted run never reaches HI/LO.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q     <= MDU_MULTU;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        op_q <= op_i;
        if (div_zero) begin
          opb_q    <= rt_value_i;
          acc_hi_q <= rs_value_i;
          acc_lo_q <= '1;
        end else if (op_i == MDU_MULTU) begin
          opb_q    <= rs_value_i;
          acc_hi_q <= '0;
          acc_lo_q <= rt_value_i;
        end else begin
          opb_q    <= rt_value_i;
          acc_hi_q <= '0;
          acc_lo_q <= rs_value_i;
        end
      end else if (state_q == MDU_RUN) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
      end
      if (state_q == MDU_COMMIT) begin
        hi_q <= acc_hi_q;
        lo_q <= acc_lo_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ---- tb_mdu_sequencer: self-checking bench for mdu_sequencer | rev 1.0 ----
`default_nettype none

module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  mdu_op_t       op_s;
  logic [W-1:0]  rs, rt;
  logic          read_req, read_sel;
  logic [W-1:0]  read_data;
  logic          busy, stall, done;

  int vectors = 0;
  int miscompares = 0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clock_i     (clock),
    .reset_ni    (reset_n),
    .start_i     (start),
    .op_i        (op_s),
    .rs_value_i  (rs),
    .rt_value_i  (rt),
    .read_req_i  (read_req),
    .read_sel_i  (read_sel),
    .read_data_o (read_data),
    .busy_o      (busy),
    .stall_o     (stall),
    .done_o      (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    mdu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic void model(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic [2*W-1:0] p;
    if (op == MDU_MULTU) begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      hi = p[2*W-1:W];
      lo = p[W-1:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endfunction

  task automatic read_check(input logic sel, input logic [W-1:0] exp, input string name);
    read_req = 1'b1;
    read_sel = sel;
    #1;
    chk({name, " stall"}, {31'b0, stall}, 32'd0);
    chk(name, read_data, exp);
    read_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
    tick();
    chk({name, " done pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic run_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    logic [W-1:0] eh, el;
    model(op, a, b, eh, el);
    start = 1'b1; op_s = op; rs = a; rt = b;
    tick();
    start = 1'b0;
    wait_done(name, (op == MDU_DIVU && b == '0) ? 0 : W);
    read_check(1'b1, eh, {name, " HI"});
    read_check(1'b0, el, {name, " LO"});
  endtask

  initial begin
    vec_t tbl[7];
    logic [W-1:0] eh, el, ra, rb;
    int bad, n;
    mdu_op_t rop;

    tbl[0] = '{MDU_MULTU, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_0000, 32'h3FFF_0001, "mul7fff_sq"};
    tbl[1] = '{MDU_MULTU, 32'h0000_7FFF, 32'h3FFF_0001, 32'h0000_1FFF, 32'h4001_7FFF, "mul7fff_3fff"};
    tbl[2] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "mul_max_sq"};
    tbl[3] = '{MDU_DIVU,  32'd257,       32'd16,        32'd1,         32'd16,        "div257_16"};
    tbl[4] = '{MDU_DIVU,  32'd5,         32'd7,         32'd5,         32'd0,         "div5_7"};
    tbl[5] = '{MDU_DIVU,  32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, "div9_0"};
    tbl[6] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, "div_max_1"};

    reset_n = 1'b0; start = 1'b0; op_s = MDU_MULTU; rs = '0; rt = '0;
    read_req = 1'b0; read_sel = 1'b0;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    read_req = 1'b1;
    #1;
    chk("reset stall", {31'b0, stall}, 32'd0);
    read_req = 1'b0;
    #10;
    reset_n = 1'b1;
    tick();
    read_check(1'b1, 32'd0, "reset HI");
    read_check(1'b0, 32'd0, "reset LO");

    foreach (tbl[i]) begin
      start = 1'b1; op_s = tbl[i].op; rs = tbl[i].a; rt = tbl[i].b;
      tick();
      start = 1'b0;
      wait_done(tbl[i].name, (tbl[i].op == MDU_DIVU && tbl[i].b == '0) ? 0 : W);
      read_check(1'b1, tbl[i].hi, {tbl[i].name, " HI"});
      read_check(1'b0, tbl[i].lo, {tbl[i].name, " LO"});
    end

    for (int k = 0; k < 24; k++) begin
      rop = mdu_op_t'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d", k));
    end

    // MFHI arrives 3 cycles into a multiply: stalls through COMMIT, then reads new HI.
    model(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, eh, el);
    start = 1'b1; op_s = MDU_MULTU; rs = 32'h1234_5678; rt = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    read_req = 1'b1; read_sel = 1'b1;
    bad = 0;
    for (int k = 3; k <= W; k++) begin
      #1;
      if (!stall) bad++;
      if (k == W) chk("rd_run done at commit", {31'b0, done}, 32'd1);
      else tick();
    end
    chk("rd_run stall cycles low", bad, 32'd0);
    tick();
    chk("rd_run stall after", {31'b0, stall}, 32'd0);
    chk("rd_run new HI", read_data, eh);
    read_req = 1'b0;

    // Back-to-back: second start held while busy, accepted in first IDLE cycle
    // alongside an older MFLO that must see the first result.
    start = 1'b1; op_s = MDU_DIVU; rs = 32'd257; rt = 32'd16;
    tick();
    op_s = MDU_MULTU; rs = 32'hDEAD_BEEF; rt = 32'h0000_0003;
    bad = 0; n = 0;
    while (busy && n < 100) begin
      if (!stall) bad++;
      tick();
      n++;
    end
    chk("b2b stall while busy", bad, 32'd0);
    chk("b2b busy cycles", n, W + 1);
    read_check(1'b0, 32'd16, "b2b first LO");
    read_check(1'b1, 32'd1, "b2b first HI");
    tick();
    start = 1'b0;
    wait_done("b2b second", W);
    model(MDU_MULTU, 32'hDEAD_BEEF, 32'h0000_0003, eh, el);
    read_check(1'b1, eh, "b2b second HI");
    read_check(1'b0, el, "b2b second LO");

    // Reset mid-run at count 10: clears everything, no done, next op normal.
    start = 1'b1; op_s = MDU_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    read_check(1'b1, 32'd0, "abort HI");
    read_check(1'b0, 32'd0, "abort LO");
    tick();
    chk("abort done held", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("abort idle busy", {31'b0, busy}, 32'd0);
    run_op(MDU_DIVU, 32'd1000, 32'd7, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
